// File: rtl/plus_periph_io_if.sv
// Z80 I/O bus bundle between the CPU-side read mux and the Plus peripheral block.
interface plus_periph_io_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_wr;
  logic        cpu_rd;
  logic [7:0]  io_dout;
  logic        io_sel;

  modport master (output cpu_addr, cpu_data, cpu_wr, cpu_rd, input io_dout, io_sel);
  modport slave  (input cpu_addr, cpu_data, cpu_wr, cpu_rd, output io_dout, io_sel);
endinterface

// File: rtl/plus_periph_io.sv
// Plus/GX4000 peripheral I/O: joystick ports, buffered Centronics printer channel, status and IRQ.
// Optional feature: define PLUS_IO_DEBOUNCE_EN for per-bit joystick debounce.
module plus_periph_io #(
  parameter int unsigned NUM_JOY     = 2,
  parameter int unsigned JOY_BITS    = 7,
  parameter logic [7:0]  BASE_ADDR   = 8'h70,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned STROBE_CYC  = 16,
  parameter int unsigned ACK_TIMEOUT = 65535,
  parameter int unsigned DEB_CYC     = 1024
) (
  input  logic                        clk_sys,
  input  logic                        reset,
  input  logic                        enable,
  plus_periph_io_if.slave             bus,
  input  logic [NUM_JOY*JOY_BITS-1:0] joy_in,
  output logic [7:0]                  printer_data,
  output logic                        printer_strobe,
  input  logic                        printer_busy,
  input  logic                        printer_ack,
  output logic                        irq
);

  localparam int unsigned JW      = NUM_JOY * JOY_BITS;
  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned PW      = AW + 1;
  localparam int unsigned CNT_MAX = (ACK_TIMEOUT > STROBE_CYC) ? ACK_TIMEOUT : STROBE_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  if (NUM_JOY < 1 || NUM_JOY > 4 || JOY_BITS < 1 || JOY_BITS > 7 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STROBE_CYC < 1 || ACK_TIMEOUT < 1 ||
      DEB_CYC < 1) begin : g_bad_param
    $error("plus_periph_io: illegal parameter value");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_STROBE, ST_WAIT_ACK} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            pop_c, tmo_set_c;

  logic            cpu_wr_q;
  logic            joy_swap, prn_en, irq_en, tmo_flag, ovf_flag;
  logic [JW-1:0]   joy_s1, joy_s2, joy_sync;
  logic            ack_s1, ack_s2, ack_s3, ack_rise_c;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q, count_c;
  logic            empty_c, full_c, fsm_active_c;
  logic [3:0]      level_c;

  logic [7:0]      off_c;
  logic            win_hit_c, gx_hit_c, wr_edge_c;
  logic            wr_ctrl_c, wr_stat_c, wr_pdata_c, push_c, flush_c;
  logic [1:0]      jn_c, ch_c;
  logic [7:0]      joy_byte_c, rd_data_c;

  // Address decode: main window is the low address byte, GX4000 compat is a full 16-bit match.
  assign off_c     = bus.cpu_addr[7:0] - BASE_ADDR;
  assign win_hit_c = (off_c < 8'd7);
  assign gx_hit_c  = ((bus.cpu_addr & 16'hFFFC) == 16'hF7F0);

  // Writes act once per cpu_wr assertion; the edge tracker runs even while disabled.
  assign wr_edge_c  = bus.cpu_wr && !cpu_wr_q && enable;
  assign wr_ctrl_c  = wr_edge_c && win_hit_c && (off_c == 8'd0);
  assign wr_stat_c  = wr_edge_c && win_hit_c && (off_c == 8'd1);
  assign wr_pdata_c = wr_edge_c && win_hit_c && (off_c == 8'd2);
  assign flush_c    = wr_ctrl_c && bus.cpu_data[7];
  assign push_c     = wr_pdata_c && !full_c;

  assign count_c      = wr_ptr_q - rd_ptr_q;
  assign empty_c      = (count_c == '0);
  assign full_c       = (count_c == PW'(FIFO_DEPTH));
  assign level_c      = (32'(count_c) > 32'd15) ? 4'hF : 4'(count_c);
  assign fsm_active_c = (state_q != ST_IDLE);
  assign ack_rise_c   = ack_s2 && !ack_s3;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cpu_wr_q <= 1'b0;
      joy_swap <= 1'b0;
      prn_en   <= 1'b0;
      irq_en   <= 1'b0;
      tmo_flag <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      cpu_wr_q <= bus.cpu_wr;
      if (wr_ctrl_c) begin
        joy_swap <= bus.cpu_data[0];
        prn_en   <= bus.cpu_data[1];
        irq_en   <= bus.cpu_data[2];
      end
      // A new timeout wins over a same-cycle clear so the event is never lost.
      if (tmo_set_c)                        tmo_flag <= 1'b1;
      else if (wr_stat_c && bus.cpu_data[3]) tmo_flag <= 1'b0;
      if (wr_pdata_c && full_c)             ovf_flag <= 1'b1;
      else if (wr_stat_c && bus.cpu_data[4]) ovf_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      joy_s1 <= '0;
      joy_s2 <= '0;
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
      ack_s3 <= 1'b0;
    end else begin
      joy_s1 <= joy_in;
      joy_s2 <= joy_s1;
      ack_s1 <= printer_ack;
      ack_s2 <= ack_s1;
      ack_s3 <= ack_s2;
    end
  end

`ifdef PLUS_IO_DEBOUNCE_EN
  localparam int unsigned DW = $clog2(DEB_CYC + 1);
  logic [DW-1:0] deb_cnt [JW];
  logic [JW-1:0] joy_deb;

  // Each bit follows its synced input only after DEB_CYC consecutive differing samples.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      joy_deb <= '0;
      for (int i = 0; i < JW; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < JW; i++) begin
        if (joy_s2[i] == joy_deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
          joy_deb[i] <= joy_s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign joy_sync = joy_deb;
`else
  assign joy_sync = joy_s2;
`endif

  // FIFO storage needs no reset; occupancy is tracked purely by the pointers.
  always_ff @(posedge clk_sys) begin
    if (push_c) mem[wr_ptr_q[AW-1:0]] <= bus.cpu_data;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (flush_c)    rd_ptr_q <= wr_ptr_q;
      else if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Printer handshake; a flush landing between IDLE and LOAD sends the FSM back without a pop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pop_c     = 1'b0;
    tmo_set_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (prn_en && !empty_c && !printer_busy) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (empty_c) begin
          state_d = ST_IDLE;
        end else begin
          pop_c   = 1'b1;
          cnt_d   = '0;
          state_d = ST_STROBE;
        end
      end
      ST_STROBE: begin
        if (cnt_q == CW'(STROBE_CYC - 1)) begin
          cnt_d   = '0;
          state_d = ST_WAIT_ACK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_WAIT_ACK: begin
        if (ack_rise_c) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
          tmo_set_c = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      printer_data   <= 8'h00;
      printer_strobe <= 1'b0;
      irq            <= 1'b0;
    end else begin
      printer_strobe <= (state_d == ST_STROBE);
      if (pop_c) printer_data <= mem[rd_ptr_q[AW-1:0]];
      irq <= irq_en && ((empty_c && !fsm_active_c) || tmo_flag || ovf_flag);
    end
  end

  // Joystick channel select with optional 0<->1 swap; absent channels read as all ones.
  always_comb begin
    jn_c = gx_hit_c && !win_hit_c ? bus.cpu_addr[1:0] : 2'(off_c - 8'd3);
    ch_c = jn_c;
    if (joy_swap && NUM_JOY >= 2 && !jn_c[1]) ch_c[0] = ~jn_c[0];
    joy_byte_c = 8'hFF;
    for (int i = 0; i < NUM_JOY; i++) begin
      if (ch_c == 2'(i)) joy_byte_c[JOY_BITS-1:0] = ~joy_sync[i*JOY_BITS +: JOY_BITS];
    end
  end

  always_comb begin
    rd_data_c = 8'hFF;
    if (win_hit_c) begin
      unique case (off_c)
        8'd0:    rd_data_c = {5'b0, irq_en, prn_en, joy_swap};
        8'd1:    rd_data_c = {3'b0, ovf_flag, tmo_flag, fsm_active_c, full_c, empty_c};
        8'd2:    rd_data_c = {4'h0, level_c};
        default: rd_data_c = joy_byte_c;
      endcase
    end else if (gx_hit_c) begin
      rd_data_c = joy_byte_c;
    end
  end

  assign bus.io_sel  = bus.cpu_rd && enable && (win_hit_c || gx_hit_c);
  assign bus.io_dout = bus.io_sel ? rd_data_c : 8'hFF;

endmodule
